bitrev_frame_ctrl: RTL and testbench

Frame sequencer for the bit-reversal reorder buffer in the user domain. It gates the handshakes between the FFT sample source and the bitrev write side, and between the bitrev read side and the downstream consumer. It enforces strict fill-then-drain of whole 2^K-sample frames, counts frames, and reports completion and abort to software-facing status and interrupt lines. Sample data bypasses this block; it passes directly between source, bitrev and sink.

---
 rtl/bitrev_frame_ctrl.sv | 163 ++++++++++++++++
 tb/tb_bitrev_frame_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/bitrev_frame_ctrl.sv
// Frame sequencer for the bit-reversal reorder buffer: gates source->bitrev and
// bitrev->sink handshakes so whole 2^K-sample frames are filled, then drained.
module bitrev_frame_ctrl #(
  parameter int K         = 6,
  parameter int FrameCntW = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic                 continuous_i,
  input  logic [FrameCntW-1:0] num_frames_i,
  input  logic                 src_valid_i,
  output logic                 src_ready_o,
  output logic                 br_valid_o,
  input  logic                 br_ready_i,
  input  logic                 br_out_valid_i,
  output logic                 br_out_ready_o,
  output logic                 snk_valid_o,
  input  logic                 snk_ready_i,
  output logic                 snk_last_o,
  output logic                 busy_o,
  output logic [1:0]           state_o,
  output logic [FrameCntW-1:0] frames_done_o,
  output logic                 irq_o,
  output logic                 err_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [K-1:0] CntMax = '1;

  state_e               state_q, state_d;
  logic [K-1:0]         wr_cnt_q, wr_cnt_d;
  logic [K-1:0]         rd_cnt_q, rd_cnt_d;
  logic [FrameCntW-1:0] frames_done_q, frames_done_d;
  logic [FrameCntW-1:0] num_frames_q, num_frames_d;
  logic                 continuous_q, continuous_d;
  logic                 abort_pending_q, abort_pending_d;
  logic                 err_q, err_d;

  logic                 wr_xfer;
  logic                 rd_xfer;
  logic                 abort_now;
  logic [FrameCntW-1:0] frames_inc;

  // Raw handshakes; only meaningful when qualified by the current state.
  assign wr_xfer    = src_valid_i & br_ready_i;
  assign rd_xfer    = br_out_valid_i & snk_ready_i;
  assign abort_now  = abort_pending_q | abort_i;
  assign frames_inc = frames_done_q + FrameCntW'(1);

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d         = state_q;
    wr_cnt_d        = wr_cnt_q;
    rd_cnt_d        = rd_cnt_q;
    frames_done_d   = frames_done_q;
    num_frames_d    = num_frames_q;
    continuous_d    = continuous_q;
    abort_pending_d = abort_pending_q;
    err_d           = err_q;
    src_ready_o     = 1'b0;
    br_valid_o      = 1'b0;
    br_out_ready_o  = 1'b0;
    snk_valid_o     = 1'b0;
    snk_last_o      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Abort wins over a simultaneous start.
        if (start_i && !abort_i) begin
          if (continuous_i || (num_frames_i != '0)) begin
            continuous_d    = continuous_i;
            num_frames_d    = num_frames_i;
            frames_done_d   = '0;
            err_d           = 1'b0;
            wr_cnt_d        = '0;
            rd_cnt_d        = '0;
            abort_pending_d = 1'b0;
            state_d         = ST_FILL;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_FILL: begin
        br_valid_o  = src_valid_i;
        src_ready_o = br_ready_i;
        if (abort_i) abort_pending_d = 1'b1;
        if (wr_xfer) begin
          wr_cnt_d = wr_cnt_q + K'(1);
          if (wr_cnt_q == CntMax) state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        snk_valid_o    = br_out_valid_i;
        br_out_ready_o = snk_ready_i;
        snk_last_o     = br_out_valid_i & (rd_cnt_q == CntMax);
        if (abort_i) abort_pending_d = 1'b1;
        if (rd_xfer) begin
          rd_cnt_d = rd_cnt_q + K'(1);
          if (rd_cnt_q == CntMax) begin
            frames_done_d = frames_inc;
            // An abort arriving with the final read still ends the run here.
            if (abort_now || (!continuous_q && (frames_inc == num_frames_q))) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_FILL;
            end
          end
        end
      end

      ST_DONE: begin
        if (abort_pending_q) err_d = 1'b1;
        abort_pending_d = 1'b0;
        state_d         = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= ST_IDLE;
      wr_cnt_q        <= '0;
      rd_cnt_q        <= '0;
      frames_done_q   <= '0;
      num_frames_q    <= '0;
      continuous_q    <= 1'b0;
      abort_pending_q <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_cnt_q        <= wr_cnt_d;
      rd_cnt_q        <= rd_cnt_d;
      frames_done_q   <= frames_done_d;
      num_frames_q    <= num_frames_d;
      continuous_q    <= continuous_d;
      abort_pending_q <= abort_pending_d;
      err_q           <= err_d;
    end
  end

  assign busy_o        = (state_q != ST_IDLE);
  assign state_o       = state_q;
  assign frames_done_o = frames_done_q;
  assign irq_o         = (state_q == ST_DONE);
  assign err_o         = err_q;

endmodule

// File: tb/tb_bitrev_frame_ctrl.sv
// Directed bench for bitrev_frame_ctrl (K=3): transaction-level model checked
// every cycle, plus literal end-of-run expectations per scenario.
module tb_bitrev_frame_ctrl;
  localparam int K     = 3;
  localparam int FW    = 16;
  localparam int FRAME = 1 << K;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic          abort_i = 1'b0;
  logic          continuous_i = 1'b0;
  logic [FW-1:0] num_frames_i = '0;
  logic          src_valid_i = 1'b0;
  logic          br_ready_i = 1'b0;
  logic          br_out_valid_i = 1'b0;
  logic          snk_ready_i = 1'b0;
  logic          src_ready_o, br_valid_o, br_out_ready_o, snk_valid_o, snk_last_o;
  logic          busy_o, irq_o, err_o;
  logic [1:0]    state_o;
  logic [FW-1:0] frames_done_o;

  int tests_run = 0;
  int tests_failed = 0;
  int cnt_wr = 0, cnt_rd = 0, cnt_last = 0, cnt_irq = 0;
  bit rnd_en = 1'b0;

  // Model state: phase 0..3 plus plain per-frame sample counts.
  int            m_phase, m_w, m_r;
  logic [FW-1:0] m_frames, m_nf;
  bit            m_cont, m_ab, m_err;

  bitrev_frame_ctrl #(.K(K), .FrameCntW(FW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .continuous_i(continuous_i), .num_frames_i(num_frames_i),
    .src_valid_i(src_valid_i), .src_ready_o(src_ready_o),
    .br_valid_o(br_valid_o), .br_ready_i(br_ready_i),
    .br_out_valid_i(br_out_valid_i), .br_out_ready_o(br_out_ready_o),
    .snk_valid_o(snk_valid_o), .snk_ready_i(snk_ready_i), .snk_last_o(snk_last_o),
    .busy_o(busy_o), .state_o(state_o), .frames_done_o(frames_done_o),
    .irq_o(irq_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_phase = 0; m_w = 0; m_r = 0; m_frames = '0; m_nf = '0;
      m_cont = 0; m_ab = 0; m_err = 0;
    end else begin
      case (m_phase)
        0: if (start_i && !abort_i) begin
          if (continuous_i || num_frames_i != 0) begin
            m_cont = continuous_i; m_nf = num_frames_i; m_frames = '0;
            m_err = 0; m_ab = 0; m_w = 0; m_r = 0; m_phase = 1;
          end else m_err = 1;
        end
        1: begin
          if (abort_i) m_ab = 1;
          if (src_valid_i && br_ready_i) begin
            m_w++;
            if (m_w == FRAME) begin m_w = 0; m_phase = 2; end
          end
        end
        2: begin
          if (abort_i) m_ab = 1;
          if (br_out_valid_i && snk_ready_i) begin
            m_r++;
            if (m_r == FRAME) begin
              m_r = 0;
              m_frames = m_frames + 16'd1;
              m_phase = (m_ab || (!m_cont && m_frames == m_nf)) ? 3 : 1;
            end
          end
        end
        default: begin
          if (m_ab) m_err = 1;
          m_ab = 0; m_phase = 0;
        end
      endcase
    end
  end

  always @(negedge clk_i) begin
    logic [31:0] act_v, exp_v;
    act_v = {6'd0, state_o, busy_o, src_ready_o, br_valid_o, br_out_ready_o,
             snk_valid_o, snk_last_o, irq_o, err_o, frames_done_o};
    exp_v = {6'd0, 2'(m_phase), m_phase != 0,
             m_phase == 1 && br_ready_i, m_phase == 1 && src_valid_i,
             m_phase == 2 && snk_ready_i, m_phase == 2 && br_out_valid_i,
             m_phase == 2 && br_out_valid_i && m_r == FRAME - 1,
             m_phase == 3, m_err, m_frames};
    check("cycle_outputs", act_v, exp_v);
    if (src_valid_i && src_ready_o) cnt_wr++;
    if (snk_valid_o && snk_ready_i) cnt_rd++;
    if (snk_last_o && snk_ready_i) cnt_last++;
    if (irq_o) cnt_irq++;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
    if (rnd_en) begin
      src_valid_i = 1'($urandom_range(0, 1));
      snk_ready_i = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic pulse_start(input logic [FW-1:0] nf, input logic cont);
    start_i = 1'b1; num_frames_i = nf; continuous_i = cont;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy_o && n < budget) begin tick(); n++; end
    check("wait_idle_timeout", 32'(busy_o), 32'd0);
  endtask

  int w0, r0, l0, i0;
  task automatic snap();
    w0 = cnt_wr; r0 = cnt_rd; l0 = cnt_last; i0 = cnt_irq;
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_state", 32'(state_o), 32'd0);
    check("reset_outs", 32'({busy_o, src_ready_o, br_valid_o, br_out_ready_o,
                             snk_valid_o, snk_last_o, irq_o, err_o}), 32'd0);
    check("reset_frames", 32'(frames_done_o), 32'd0);
    rst_i = 1'b0;
    tick();
    src_valid_i = 1; br_ready_i = 1; br_out_valid_i = 1; snk_ready_i = 1;

    // Two frames, no stalls
    snap();
    pulse_start(16'd2, 1'b0);
    wait_idle(200);
    check("t1_writes", 32'(cnt_wr - w0), 32'd16);
    check("t1_reads", 32'(cnt_rd - r0), 32'd16);
    check("t1_lasts", 32'(cnt_last - l0), 32'd2);
    check("t1_irq", 32'(cnt_irq - i0), 32'd1);
    check("t1_frames", 32'(frames_done_o), 32'd2);
    check("t1_err", 32'(err_o), 32'd0);
    check("t1_state", 32'(state_o), 32'd0);

    // Three frames with random source/sink stalls
    snap();
    rnd_en = 1'b1;
    pulse_start(16'd3, 1'b0);
    wait_idle(2000);
    rnd_en = 1'b0; src_valid_i = 1; snk_ready_i = 1;
    check("t2_writes", 32'(cnt_wr - w0), 32'd24);
    check("t2_reads", 32'(cnt_rd - r0), 32'd24);
    check("t2_lasts", 32'(cnt_last - l0), 32'd3);
    check("t2_frames", 32'(frames_done_o), 32'd3);
    check("t2_irq", 32'(cnt_irq - i0), 32'd1);

    // Zero-frame start is an error; next valid start clears it
    snap();
    pulse_start(16'd0, 1'b0);
    tick(); tick();
    check("t4_state", 32'(state_o), 32'd0);
    check("t4_err", 32'(err_o), 32'd1);
    check("t4_irq", 32'(cnt_irq - i0), 32'd0);
    pulse_start(16'd1, 1'b0);
    check("t4_fill", 32'(state_o), 32'd1);
    check("t4_err_clr", 32'(err_o), 32'd0);
    wait_idle(200);
    check("t4_frames", 32'(frames_done_o), 32'd1);

    // Start with abort in IDLE, then start during DRAIN
    start_i = 1; abort_i = 1; num_frames_i = 16'd1; continuous_i = 0;
    tick();
    start_i = 0; abort_i = 0;
    check("t5_abort_wins", 32'(state_o), 32'd0);
    check("t5_frames_kept", 32'(frames_done_o), 32'd1);
    snap();
    pulse_start(16'd2, 1'b0);
    for (int n = 0; n < 100 && state_o != 2'd2; n++) tick();
    check("t5_in_drain", 32'(state_o), 32'd2);
    pulse_start(16'd5, 1'b1);
    wait_idle(300);
    check("t5_frames", 32'(frames_done_o), 32'd2);
    check("t5_irq", 32'(cnt_irq - i0), 32'd1);
    check("t5_err", 32'(err_o), 32'd0);

    // Continuous run aborted after write 5 of frame 4
    snap();
    pulse_start(16'd0, 1'b1);
    for (int n = 0; n < 500 && (cnt_wr - w0) < 3 * FRAME + 5; n++) tick();
    check("t3_abort_point", 32'(cnt_wr - w0), 32'(3 * FRAME + 5));
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    wait_idle(500);
    check("t3_frames", 32'(frames_done_o), 32'd4);
    check("t3_err", 32'(err_o), 32'd1);
    check("t3_irq", 32'(cnt_irq - i0), 32'd1);
    check("t3_writes", 32'(cnt_wr - w0), 32'd32);
    check("t3_reads", 32'(cnt_rd - r0), 32'd32);

    // Async reset during FILL, then a fresh run
    snap();
    pulse_start(16'd1, 1'b0);
    for (int n = 0; n < 100 && (cnt_wr - w0) < 3; n++) tick();
    rst_i = 1'b1;
    #1;
    check("t6_rst_state", 32'(state_o), 32'd0);
    check("t6_rst_outs", 32'({busy_o, src_ready_o, br_valid_o, br_out_ready_o,
                              snk_valid_o, snk_last_o, irq_o, err_o}), 32'd0);
    check("t6_rst_frames", 32'(frames_done_o), 32'd0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    tick();
    snap();
    pulse_start(16'd1, 1'b0);
    wait_idle(200);
    check("t6_frames", 32'(frames_done_o), 32'd1);
    check("t6_writes", 32'(cnt_wr - w0), 32'd8);
    check("t6_reads", 32'(cnt_rd - r0), 32'd8);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
